// File: rtl/arb_types.sv
// Shared types for the instruction/data memory-port arbiter: FSM states, requester IDs,
// operation codes and the exclude-mask encoding used by the winner select.
package arb_types;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } arb_req_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } arb_op_t;

  // Exclude mask: bit 0 masks the fetch requester, bit 1 masks the data requester.
  localparam logic [1:0] EXCL_NONE = 2'b00;
  localparam logic [1:0] EXCL_I    = 2'b01;
  localparam logic [1:0] EXCL_D    = 2'b10;

  function automatic arb_req_t other_req(input arb_req_t r);
    return (r == REQ_I) ? REQ_D : REQ_I;
  endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational winner select between the fetch and data requesters. Masked requesters are
// ignored; on a tie the requester named by ptr wins.
module arb_pick
  import arb_types::*;
(
  input  logic       pend_i,
  input  logic       pend_d,
  input  logic [1:0] excl,
  input  arb_req_t   ptr,
  output arb_req_t   winner,
  output logic       valid
);

  logic cand_i;
  logic cand_d;

  always_comb begin
    cand_i = pend_i & ~excl[0];
    cand_d = pend_d & ~excl[1];
    valid  = cand_i | cand_d;
    if (cand_i && cand_d) begin
      winner = ptr;
    end else if (cand_d) begin
      winner = REQ_D;
    end else begin
      winner = REQ_I;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data requesters onto one registered memory port.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin; otherwise data has fixed priority over fetch.
module mem_port_arbiter
  import arb_types::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                instr_read,
  input  logic [ADDR_W-1:0]   instr_addr,
  output logic [DATA_W-1:0]   instr_rdata,
  output logic                instr_resp,
  input  logic                data_read,
  input  logic                data_write,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  input  logic [DATA_W/8-1:0] data_mbe,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                data_resp,
  output logic                mem_read,
  output logic                mem_write,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_mbe,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_resp
);

  localparam int unsigned MbeW = DATA_W / 8;

  typedef struct packed {
    arb_op_t           op;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [MbeW-1:0]   mbe;
  } port_req_t;

  arb_state_t        state_q, state_d;
  port_req_t         req_new;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [MbeW-1:0]   mbe_q;
  logic              rd_q, wr_q;

  logic              pend_i, pend_d;
  logic [1:0]        excl;
  arb_req_t          ptr;
  arb_req_t          pick_win;
  logic              pick_valid;
  logic              done;
  logic              take;

  assign pend_i = instr_read;
  assign pend_d = data_read | data_write;
  assign done   = (state_q != IDLE) & mem_resp;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  arb_req_t rr_q;
  arb_req_t served;

  assign served = (state_q == SERVE_D) ? REQ_D : REQ_I;

  // Pointer names the requester preferred on the next tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_q <= REQ_D;
    end else if (done) begin
      rr_q <= other_req(served);
    end
  end

  assign ptr = rr_q;
`else
  assign ptr = REQ_D;
`endif

  // The just-served requester still holds its request during the response cycle.
  always_comb begin
    excl = EXCL_NONE;
    if (mem_resp) begin
      case (state_q)
        SERVE_I: excl = EXCL_I;
        SERVE_D: excl = EXCL_D;
        default: excl = EXCL_NONE;
      endcase
    end
  end

  arb_pick u_arb_pick (
    .pend_i (pend_i),
    .pend_d (pend_d),
    .excl   (excl),
    .ptr    (ptr),
    .winner (pick_win),
    .valid  (pick_valid)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    unique case (state_q)
      IDLE, SERVE_I, SERVE_D: begin
        if (state_q == IDLE || done) begin
          take = pick_valid;
          if (pick_valid) begin
            state_d = (pick_win == REQ_D) ? SERVE_D : SERVE_I;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Read-and-write together is treated as a write; reads present all-ones byte enables.
  always_comb begin
    req_new = '0;
    if (pick_win == REQ_D) begin
      req_new.op    = data_write ? OP_WRITE : OP_READ;
      req_new.addr  = data_addr;
      req_new.wdata = data_wdata;
      req_new.mbe   = data_write ? data_mbe : {MbeW{1'b1}};
    end else begin
      req_new.op    = OP_READ;
      req_new.addr  = instr_addr;
      req_new.wdata = '0;
      req_new.mbe   = {MbeW{1'b1}};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      mbe_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else if (take) begin
      addr_q  <= req_new.addr;
      wdata_q <= req_new.wdata;
      mbe_q   <= req_new.mbe;
      rd_q    <= (req_new.op == OP_READ);
      wr_q    <= (req_new.op == OP_WRITE);
    end else if (done) begin
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end
  end

  always_comb begin
    mem_read    = rd_q;
    mem_write   = wr_q;
    mem_addr    = addr_q;
    mem_wdata   = wdata_q;
    mem_mbe     = mbe_q;
    instr_resp  = (state_q == SERVE_I) & mem_resp;
    data_resp   = (state_q == SERVE_D) & mem_resp;
    instr_rdata = mem_rdata;
    data_rdata  = mem_rdata;
  end

endmodule
